// File: rtl/dm_pkg.sv
// Shared encodings for the sized data memory: access sizes and FSM states.
package dm_pkg;

  // Access size field as driven by the MEM-stage control.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;  // reserved, always answered with err

  // Access sequencing states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // True when an access of the given size at the given byte offset is illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_align.sv
// Lane steering for the sized memory: byte enables and replicated write data
// for stores, lane selection plus sign/zero extension for loads.
module dm_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] din,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store side: which lanes to write and the data placed on every lane.
  always_comb begin
    be    = 4'b0000;
    wdata = din;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{din[7:0]}};
      end
      SZ_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      SZ_W: begin
        be    = 4'b1111;
        wdata = din;
      end
      default: begin
        be    = 4'b0000;
        wdata = din;
      end
    endcase
  end

  // Load side: pick the addressed lane(s), then extend to 32 bits.
  always_comb begin
    rbyte = rword[7:0];
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B:    rdata_ext = {{24{sext & rbyte[7]}}, rbyte};
      SZ_H:    rdata_ext = {{16{sext & rhalf[15]}}, rhalf};
      default: rdata_ext = rword;
    endcase
  end

  assign misalign = is_misaligned(size, addr_lo);

endmodule

// File: rtl/dm_sized.sv
// Byte-addressed data memory with byte/half/word accesses, a req/ready
// handshake with a fixed number of wait states, and an alignment error.
module dm_sized
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [31:0]       dout
);

  localparam int         DEPTH     = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic       NO_WAIT   = (WAIT == 0);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              sext_q, sext_d;
  logic [31:0]       din_q, din_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;

  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] op_addr;
  logic [1:0]        op_size;
  logic              op_write;
  logic              op_sext;
  logic [31:0]       op_din;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata_ext;
  logic              misalign;
  logic              wr_en;

  // A new request is taken whenever no access is waiting (IDLE or RESP).
  assign accept = req && (state_q != S_WAIT);

  // The commit edge is the one entering RESP. With zero wait states that is
  // the acceptance edge itself, so the operands come straight from the ports;
  // otherwise they come from the capture registers. Reset on that edge
  // cancels the access entirely.
  assign commit = !rst && ((state_q == S_WAIT && cnt_q == 4'd0) || (accept && NO_WAIT));

  assign op_addr  = accept ? addr  : addr_q;
  assign op_size  = accept ? size  : size_q;
  assign op_write = accept ? write : write_q;
  assign op_sext  = accept ? sext  : sext_q;
  assign op_din   = accept ? din   : din_q;
  assign word_idx = op_addr[ADDR_W-1:2];
  assign wr_en    = commit && op_write && !misalign;

  dm_align u_align (
    .addr_lo   (op_addr[1:0]),
    .size      (op_size),
    .sext      (op_sext),
    .din       (op_din),
    .rword     (rword),
    .be        (be),
    .wdata     (wdata),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  // One byte-wide array per lane. The read is asynchronous because the load
  // result must be extended and registered into dout on the same commit edge
  // that a just-committed store may have updated.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      // Lane write, gated by its byte enable; contents survive reset.
      always_ff @(posedge clk) begin
        if (wr_en && be[gi]) begin
          mem[word_idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rword[gi*8 +: 8] = mem[word_idx];
    end
  endgenerate

  // Next-state, wait counter, operand capture and response register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    sext_d  = sext_q;
    din_d   = din_q;
    err_d   = err_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          addr_d  = addr;
          size_d  = size;
          write_d = write;
          sext_d  = sext;
          din_d   = din;
          if (NO_WAIT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      err_d = misalign;
      if (!op_write && !misalign) begin
        dout_d = rdata_ext;
      end
    end
  end

  // Control and response registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Operand capture registers; only meaningful after an acceptance.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    write_q <= write_d;
    sext_q  <= sext_d;
    din_q   <= din_d;
  end

  assign busy  = (state_q == S_WAIT);
  assign ready = (state_q == S_RESP);
  assign err   = ready && err_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_dm_sized.sv
// Randomised and directed bench for dm_sized (WAIT=1) against a byte-array
// reference of the memory and the expected load result.
module tb_dm_sized;

  localparam int ADDR_W = 10;
  localparam int NBYTES = 2 ** ADDR_W;

  logic              clk;
  logic              rst;
  logic              req;
  logic              write;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic              busy;
  logic              ready;
  logic              err;
  logic [31:0]       dout;

  int checks;
  int errors;

  // Reference state: memory as plain bytes, and the last successful load.
  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_dout;

  dm_sized #(.ADDR_W(ADDR_W), .WAIT(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .write (write),
    .size  (size),
    .sext  (sext),
    .addr  (addr),
    .din   (din),
    .busy  (busy),
    .ready (ready),
    .err   (err),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one access to the reference: returns whether it is an error and
  // updates memory / expected load value from the little-endian byte rules.
  task automatic ref_access(input logic wr, input logic [1:0] sz, input logic sx,
                            input int a, input logic [31:0] d, output logic e);
    int n;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    if (!e) begin
      n = 1 << sz;
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
        if (sx && n < 4 && v[8*n - 1]) begin
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        exp_dout = v;
      end
    end
  endtask

  // Scramble the request inputs so that latched operands are really tested.
  task automatic scramble();
    write = 1'($urandom);
    size  = 2'($urandom_range(0, 3));
    sext  = 1'($urandom);
    addr  = ADDR_W'($urandom);
    din   = $urandom;
  endtask

  // One complete access from IDLE: check busy in WAIT and the RESP outputs.
  task automatic access(input logic wr, input logic [1:0] sz, input logic sx,
                        input int a, input logic [31:0] d);
    logic e;
    @(negedge clk);
    req = 1'b1; write = wr; size = sz; sext = sx; addr = ADDR_W'(a); din = d;
    @(negedge clk);
    req = 1'b0;
    scramble();
    check_eq("busy_wait", 32'(busy), 32'd1);
    check_eq("ready_wait", 32'(ready), 32'd0);
    ref_access(wr, sz, sx, a, d, e);
    @(negedge clk);
    check_eq("ready_resp", 32'(ready), 32'd1);
    check_eq("busy_resp", 32'(busy), 32'd0);
    check_eq("err_resp", 32'(err), 32'(e));
    check_eq("dout_resp", dout, exp_dout);
    $display("access wr=%0d size=%0d sext=%0d addr=%h din=%h -> err=%0d dout=%h",
             wr, sz, sx, a, d, err, dout);
  endtask

  initial begin
    logic e;
    checks = 0;
    errors = 0;
    exp_dout = 32'd0;
    rst = 1'b1; req = 1'b0; write = 1'b0; size = 2'd0; sext = 1'b0;
    addr = '0; din = 32'd0;

    // Reset for two cycles, then check the idle outputs.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_dout", dout, 32'd0);

    // Give every word in the test window a defined value.
    for (int w = 0; w < 16; w++) access(1'b1, 2'd2, 1'b0, w * 4, $urandom);

    // Word store/load, then sub-word merge and extension.
    access(1'b1, 2'd2, 1'b0, 'h04, 32'h12345678);
    access(1'b0, 2'd2, 1'b0, 'h04, 32'd0);
    check_eq("lw_04_const", dout, 32'h12345678);
    access(1'b1, 2'd0, 1'b0, 'h05, 32'h000000AA);
    access(1'b0, 2'd2, 1'b0, 'h04, 32'd0);
    check_eq("lw_merge_const", dout, 32'h1234AA78);
    access(1'b0, 2'd0, 1'b1, 'h05, 32'd0);
    check_eq("lb_const", dout, 32'hFFFFFFAA);
    access(1'b0, 2'd0, 1'b0, 'h05, 32'd0);
    check_eq("lbu_const", dout, 32'h000000AA);
    access(1'b0, 2'd1, 1'b1, 'h06, 32'd0);
    check_eq("lh_const", dout, 32'h00001234);

    // Error responses: misaligned half store, misaligned word load, reserved size.
    access(1'b1, 2'd1, 1'b0, 'h03, 32'h0000BEEF);
    access(1'b0, 2'd2, 1'b0, 'h06, 32'd0);
    access(1'b0, 2'd3, 1'b0, 'h08, 32'd0);
    access(1'b0, 2'd2, 1'b0, 'h00, 32'd0);

    // A req pulse during WAIT (a store to 0x20) must be dropped.
    @(negedge clk);
    req = 1'b1; write = 1'b0; size = 2'd2; sext = 1'b0; addr = 'h04; din = 32'd0;
    @(negedge clk);
    req = 1'b1; write = 1'b1; size = 2'd2; addr = 'h20; din = 32'hCAFEF00D;
    check_eq("pulse_busy", 32'(busy), 32'd1);
    ref_access(1'b0, 2'd2, 1'b0, 'h04, 32'd0, e);
    @(negedge clk);
    req = 1'b0;
    check_eq("pulse_ready", 32'(ready), 32'd1);
    check_eq("pulse_dout", dout, exp_dout);
    @(negedge clk);
    check_eq("pulse_no_ready", 32'(ready), 32'd0);
    check_eq("pulse_no_busy", 32'(busy), 32'd0);
    access(1'b0, 2'd2, 1'b0, 'h20, 32'd0);

    // Store, then a load of the same word held through RESP: back-to-back.
    @(negedge clk);
    req = 1'b1; write = 1'b1; size = 2'd2; sext = 1'b0; addr = 'h0C; din = 32'h0BADCAFE;
    @(negedge clk);
    write = 1'b0; size = 2'd2; addr = 'h0C; din = 32'd0;
    check_eq("b2b_busy1", 32'(busy), 32'd1);
    ref_access(1'b1, 2'd2, 1'b0, 'h0C, 32'h0BADCAFE, e);
    @(negedge clk);
    check_eq("b2b_ready1", 32'(ready), 32'd1);
    check_eq("b2b_err1", 32'(err), 32'd0);
    @(negedge clk);
    req = 1'b0;
    check_eq("b2b_busy2", 32'(busy), 32'd1);
    ref_access(1'b0, 2'd2, 1'b0, 'h0C, 32'd0, e);
    @(negedge clk);
    check_eq("b2b_ready2", 32'(ready), 32'd1);
    check_eq("b2b_dout", dout, exp_dout);
    check_eq("b2b_dout_const", dout, 32'h0BADCAFE);
    $display("back-to-back sw/lw 0x0C -> dout=%h", dout);

    // Reset on the commit edge of a store: no ready, store suppressed.
    @(negedge clk);
    req = 1'b1; write = 1'b1; size = 2'd2; addr = 'h08; din = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dout = 32'd0;
    check_eq("rmid_ready", 32'(ready), 32'd0);
    check_eq("rmid_busy", 32'(busy), 32'd0);
    check_eq("rmid_dout", dout, 32'd0);
    @(negedge clk);
    check_eq("rmid_ready2", 32'(ready), 32'd0);
    access(1'b0, 2'd2, 1'b0, 'h08, 32'd0);
    $display("reset mid-store 0x08 -> lw returns %h", dout);

    // Random mix of sizes, directions and offsets within the defined window.
    for (int t = 0; t < 60; t++) begin
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, 63)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

endmodule
